ball_motion_engine: RTL and testbench

//   Game-logic stage directly upstream of the VGA renderer: moves the tennis ball once per frame,

---
 rtl/ball_motion_engine_if.sv | 44 ++++
 rtl/ball_motion_engine.sv | 207 ++++++++++++++++++++
 tb/tb_ball_motion_engine.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_engine_if.sv
// ---------------------------------------------------------------------------
// ball_motion_engine_if
//   Groups the frame-level control inputs and the ball state outputs of the
//   ball motion engine. Clock and reset stay outside the bundle.
//
//   master : game/test side; drives vSync, paddleY, serve, serveUp and
//            observes the ball outputs.
//   slave  : the engine; consumes the controls and drives the ball outputs.
//
//   Signals
//     vSync       vertical sync from the sync generator (pixel-clock domain)
//     paddleY     top y of the right paddle
//     serve       level request to launch the ball from IDLE
//     serveUp     launch direction: 1 = up, 0 = down
//     ballX/ballY ball top-left corner
//     ballVisible ball drawn by the renderer
//     state       00 IDLE, 01 RUN, 10 MISS
//     hitPulse    one-cycle paddle hit event
//     missPulse   one-cycle miss event
//     hitCount    paddle hits since last serve, saturating
// ---------------------------------------------------------------------------
interface ball_motion_engine_if;
    logic       vSync;
    logic [9:0] paddleY;
    logic       serve;
    logic       serveUp;
    logic [9:0] ballX;
    logic [9:0] ballY;
    logic       ballVisible;
    logic [1:0] state;
    logic       hitPulse;
    logic       missPulse;
    logic [7:0] hitCount;

    modport master (
        output vSync, paddleY, serve, serveUp,
        input  ballX, ballY, ballVisible, state, hitPulse, missPulse, hitCount
    );

    modport slave (
        input  vSync, paddleY, serve, serveUp,
        output ballX, ballY, ballVisible, state, hitPulse, missPulse, hitCount
    );
endinterface

// File: rtl/ball_motion_engine.sv
// ---------------------------------------------------------------------------
// ball_motion_engine
//   Game-logic stage feeding the VGA renderer. Once per frame (rising edge of
//   vSync) the ball is moved, bounced off the top/bottom/left borders and the
//   right paddle, and a miss is flagged when it reaches the right border.
//
//   Ports
//     inClock  pixel clock, all logic on its rising edge
//     reset    synchronous, active-high
//     bus      ball_motion_engine_if.slave (controls in, ball state out)
//
//   Every output is a register; a frame update is visible the cycle after
//   the tick cycle. Only the event pulses change on non-tick cycles (they
//   clear).
// ---------------------------------------------------------------------------
module ball_motion_engine #(
    parameter int H_VISIBLE   = 1024,
    parameter int V_VISIBLE   = 768,
    parameter int BORDER      = 16,
    parameter int BALL_SIZE   = 16,
    parameter int PADDLE_X    = 976,
    parameter int PADDLE_H    = 96,
    parameter int SPEED_X     = 4,
    parameter int SPEED_Y     = 3,
    parameter int SERVE_X     = 504,
    parameter int SERVE_Y     = 376,
    parameter int MISS_FRAMES = 60
) (
    input  logic                 inClock,
    input  logic                 reset,
    ball_motion_engine_if.slave  bus
);

    localparam int CNT_W = $clog2(MISS_FRAMES);

    // Motion arithmetic runs in 12-bit signed so that a step past 0 or past
    // 1023 is seen as such instead of wrapping inside the 10-bit position.
    localparam logic signed [11:0] SPD_X  = 12'(SPEED_X);
    localparam logic signed [11:0] SPD_Y  = 12'(SPEED_Y);
    localparam logic signed [11:0] BRD_S  = 12'(BORDER);
    localparam logic signed [11:0] BS_S   = 12'(BALL_SIZE);
    localparam logic signed [11:0] PX_S   = 12'(PADDLE_X);
    localparam logic signed [11:0] XLIM_S = 12'(H_VISIBLE - BORDER);
    localparam logic signed [11:0] YLIM_S = 12'(V_VISIBLE - BORDER);

    localparam logic [9:0] X_LEFT   = 10'(BORDER);
    localparam logic [9:0] X_PADDLE = 10'(PADDLE_X - BALL_SIZE);
    localparam logic [9:0] X_RIGHT  = 10'(H_VISIBLE - BORDER - BALL_SIZE);
    localparam logic [9:0] Y_TOP    = 10'(BORDER);
    localparam logic [9:0] Y_BOTTOM = 10'(V_VISIBLE - BORDER - BALL_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_MISS = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    state_t           st;
    logic [9:0]       ball_x;
    logic [9:0]       ball_y;
    logic             vx_neg;      // direction only; magnitudes are fixed
    logic             vy_neg;
    logic [7:0]       hit_count;
    logic [CNT_W-1:0] miss_cnt;
    logic             vsync_q;
    logic             hit_pulse;
    logic             miss_pulse;
    logic             visible;

    logic tick;
    assign tick = bus.vSync & ~vsync_q;

    // ------------------------------------------------------------------
    // RUN-state candidate update, resolved per axis from current values.
    // ------------------------------------------------------------------
    logic signed [11:0] nx, ny;
    logic [10:0]        y_ext, p_ext, x_ext;
    logic               overlap, crossing, run_hit, run_miss;
    logic [9:0]         run_x, run_y;
    logic               run_vx_neg, run_vy_neg;

    always_comb begin
        nx = $signed({2'b00, ball_x}) + (vx_neg ? -SPD_X : SPD_X);
        ny = $signed({2'b00, ball_y}) + (vy_neg ? -SPD_Y : SPD_Y);

        // Paddle tests use the pre-update y and 11 bits so paddleY+PADDLE_H
        // near the bottom of the range cannot wrap.
        y_ext   = {1'b0, ball_y};
        p_ext   = {1'b0, bus.paddleY};
        x_ext   = {1'b0, ball_x};
        overlap = (y_ext + 11'(BALL_SIZE) > p_ext) &&
                  (y_ext < p_ext + 11'(PADDLE_H));
        // Hit only when the leading edge crosses PADDLE_X this frame; a ball
        // already behind the paddle face can only go on to miss.
        crossing = !vx_neg &&
                   (x_ext + 11'(BALL_SIZE) <= 11'(PADDLE_X)) &&
                   (nx + BS_S > PX_S);

        run_y      = ny[9:0];
        run_vy_neg = vy_neg;
        if (ny < BRD_S) begin
            run_y      = Y_TOP;
            run_vy_neg = 1'b0;
        end else if (ny + BS_S > YLIM_S) begin
            run_y      = Y_BOTTOM;
            run_vy_neg = 1'b1;
        end

        run_x      = nx[9:0];
        run_vx_neg = vx_neg;
        run_hit    = 1'b0;
        run_miss   = 1'b0;
        if (nx < BRD_S) begin
            run_x      = X_LEFT;
            run_vx_neg = 1'b0;
        end else if (crossing && overlap) begin
            run_x      = X_PADDLE;
            run_vx_neg = 1'b1;
            run_hit    = 1'b1;
        end else if (nx + BS_S > XLIM_S) begin
            run_x      = X_RIGHT;
            run_miss   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State machine and all registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge inClock) begin
        if (reset) begin
            st         <= S_IDLE;
            ball_x     <= 10'(SERVE_X);
            ball_y     <= 10'(SERVE_Y);
            vx_neg     <= 1'b0;
            vy_neg     <= 1'b1;
            hit_count  <= '0;
            miss_cnt   <= '0;
            vsync_q    <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            visible    <= 1'b0;
        end else begin
            vsync_q    <= bus.vSync;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (tick && bus.serve) begin
                        st        <= S_RUN;
                        visible   <= 1'b1;
                        vx_neg    <= 1'b0;
                        vy_neg    <= bus.serveUp;
                        hit_count <= '0;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        ball_x <= run_x;
                        ball_y <= run_y;
                        vx_neg <= run_vx_neg;
                        vy_neg <= run_vy_neg;
                        if (run_hit) begin
                            hit_pulse <= 1'b1;
                            if (hit_count != 8'hFF)
                                hit_count <= hit_count + 8'd1;
                        end
                        if (run_miss) begin
                            st         <= S_MISS;
                            miss_pulse <= 1'b1;
                            miss_cnt   <= '0;
                        end
                    end
                end
                S_MISS: begin
                    // Ball stays frozen at the right border while the miss
                    // is shown, then returns to the serve spot.
                    if (tick) begin
                        if (miss_cnt == CNT_W'(MISS_FRAMES - 1)) begin
                            st      <= S_IDLE;
                            visible <= 1'b0;
                            ball_x  <= 10'(SERVE_X);
                            ball_y  <= 10'(SERVE_Y);
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    st      <= S_IDLE;
                    visible <= 1'b0;
                    ball_x  <= 10'(SERVE_X);
                    ball_y  <= 10'(SERVE_Y);
                end
            endcase
        end
    end

    assign bus.ballX       = ball_x;
    assign bus.ballY       = ball_y;
    assign bus.ballVisible = visible;
    assign bus.state       = st;
    assign bus.hitPulse    = hit_pulse;
    assign bus.missPulse   = miss_pulse;
    assign bus.hitCount    = hit_count;

endmodule

// File: tb/tb_ball_motion_engine.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_engine
//   Drives frames into ball_motion_engine and follows every clock cycle with
//   a reference model written directly from the game rules using integers.
// ---------------------------------------------------------------------------
module tb_ball_motion_engine;

    localparam int H_VIS = 1024, V_VIS = 768, BRD = 16, BS = 16;
    localparam int PAD_X = 976, PAD_H = 96, SPX = 4, SPY = 3;
    localparam int SRV_X = 504, SRV_Y = 376, MISS_N = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ball_motion_engine_if bus ();

    ball_motion_engine dut (
        .inClock (clk),
        .reset   (rst),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    // reference model: 0 IDLE, 1 RUN, 2 MISS
    int m_st, m_x, m_y, m_vx, m_vy, m_hits, m_mc;
    bit m_prev, m_hp, m_mp;

    // per-test cycle-by-cycle mismatch record
    int          mm_cnt;
    logic [32:0] mm_got, mm_exp;

    logic [32:0] dut_vec;
    assign dut_vec = {bus.ballX, bus.ballY, bus.ballVisible, bus.state,
                      bus.hitPulse, bus.missPulse, bus.hitCount};

    // frame capture from the update cycle
    bit last_hit, last_miss;

    function automatic logic [32:0] exp_vec();
        exp_vec = {10'(m_x), 10'(m_y), (m_st != 0), 2'(m_st), m_hp, m_mp, 8'(m_hits)};
    endfunction

    function automatic void model_reset();
        m_st = 0; m_x = SRV_X; m_y = SRV_Y; m_vx = SPX; m_vy = -SPY;
        m_hits = 0; m_mc = 0; m_prev = 0; m_hp = 0; m_mp = 0;
    endfunction

    function automatic void model_frame(int pad, bit srv, bit up);
        int nx, ny, new_y;
        case (m_st)
            0: if (srv) begin
                m_st = 1; m_vx = SPX; m_vy = up ? -SPY : SPY; m_hits = 0;
            end
            1: begin
                nx = m_x + m_vx;
                ny = m_y + m_vy;
                if (ny < BRD) begin new_y = BRD; m_vy = SPY; end
                else if (ny + BS > V_VIS - BRD) begin new_y = V_VIS - BRD - BS; m_vy = -SPY; end
                else new_y = ny;
                if (nx < BRD) begin
                    m_x = BRD; m_vx = SPX;
                end else if (m_vx > 0 && m_x + BS <= PAD_X && nx + BS > PAD_X &&
                             m_y + BS > pad && m_y < pad + PAD_H) begin
                    m_x = PAD_X - BS; m_vx = -SPX; m_hp = 1;
                    if (m_hits < 255) m_hits++;
                end else if (nx + BS > H_VIS - BRD) begin
                    m_x = H_VIS - BRD - BS; m_st = 2; m_mp = 1; m_mc = 0;
                end else m_x = nx;
                m_y = new_y;
            end
            2: begin
                if (m_mc == MISS_N - 1) begin m_st = 0; m_x = SRV_X; m_y = SRV_Y; end
                else m_mc++;
            end
            default: ;
        endcase
    endfunction

    // One clock: sample inputs, advance DUT and model, record any divergence.
    task automatic step();
        bit tk, vs, srv, up;
        int pad;
        vs  = bus.vSync;
        tk  = vs && !m_prev;
        pad = bus.paddleY;
        srv = bus.serve;
        up  = bus.serveUp;
        @(posedge clk);
        m_hp = 0; m_mp = 0;
        if (rst) model_reset();
        else begin
            m_prev = vs;
            if (tk) model_frame(pad, srv, up);
        end
        #1;
        if (dut_vec !== exp_vec()) begin
            if (mm_cnt == 0) begin mm_got = dut_vec; mm_exp = exp_vec(); end
            mm_cnt++;
        end
    endtask

    task automatic frame(int gap, int hold);
        bus.vSync = 1'b1;
        step();
        last_hit  = bus.hitPulse;
        last_miss = bus.missPulse;
        repeat (hold - 1) step();
        bus.vSync = 1'b0;
        repeat (gap) step();
    endtask

    // paddle placed so its span always covers the ball's current y
    function automatic logic [9:0] track_pad();
        int p;
        p = m_y - int'($urandom_range(0, 80));
        if (p < 0) p = 0;
        if (p > 672) p = 672;
        return 10'(p);
    endfunction

    function automatic logic [9:0] avoid_pad();
        return (m_y > 384) ? 10'd0 : 10'd600;
    endfunction

    task automatic restart(bit up);
        rst = 1'b1; step(); rst = 1'b0; step();
        bus.serve = 1'b1; bus.serveUp = up;
        frame(2, 1);
        bus.serve = 1'b0;
    endtask

    task automatic test_reset();
        mm_cnt = 0;
        rst = 1'b1; bus.vSync = 1'b0; bus.serve = 1'b0; bus.serveUp = 1'b0; bus.paddleY = 10'd300;
        step(); step();
        tests++;
        if (bus.state !== 2'b00 || bus.ballX !== 10'd504 || bus.ballY !== 10'd376 ||
            bus.ballVisible !== 1'b0 || bus.hitCount !== 8'd0 || bus.hitPulse !== 1'b0 || bus.missPulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_values got=%h want state0 pos(504,376) invisible", dut_vec);
        end
        rst = 1'b0; step();
        tests++;
        if (mm_cnt != 0) begin fails++; $display("FAIL reset_model got=%h want=%h", mm_got, mm_exp); end
    endtask

    task automatic test_serve();
        mm_cnt = 0;
        bus.serve = 1'b1; bus.serveUp = 1'b0;
        bus.vSync = 1'b1; step();
        tests++;
        if (bus.state !== 2'b01 || bus.ballX !== 10'd504 || bus.ballY !== 10'd376 || bus.ballVisible !== 1'b1) begin
            fails++;
            $display("FAIL serve_launch got state=%0d (%0d,%0d) want state=1 (504,376)", bus.state, bus.ballX, bus.ballY);
        end
        bus.vSync = 1'b0; step(); step();
        bus.serve = 1'b0;
        frame(2, 1);
        tests++;
        if (bus.ballX !== 10'd508 || bus.ballY !== 10'd379) begin
            fails++;
            $display("FAIL serve_first_move got (%0d,%0d) want (508,379)", bus.ballX, bus.ballY);
        end
        tests++;
        if (mm_cnt != 0) begin fails++; $display("FAIL serve_model got=%h want=%h", mm_got, mm_exp); end
    endtask

    task automatic test_hit();
        int f;
        bit seen;
        mm_cnt = 0;
        restart(1'b1);
        seen = 0;
        for (f = 0; f < 600 && !seen; f++) begin
            bus.paddleY = track_pad();
            frame($urandom_range(1, 3), 1);
            if (last_hit) begin
                seen = 1;
                tests++;
                if (bus.ballX !== 10'd960 || bus.hitCount !== 8'd1) begin
                    fails++;
                    $display("FAIL hit_first got x=%0d cnt=%0d want x=960 cnt=1", bus.ballX, bus.hitCount);
                end
            end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL hit_timeout got no hitPulse in %0d frames want one", f); end
        tests++;
        if (mm_cnt != 0) begin fails++; $display("FAIL hit_model got=%h want=%h", mm_got, mm_exp); end
    endtask

    task automatic test_miss();
        int f, n;
        bit seen;
        mm_cnt = 0;
        restart(1'b0);
        seen = 0;
        for (f = 0; f < 600 && !seen; f++) begin
            bus.paddleY = avoid_pad();
            frame(1, 1);
            if (bus.state == 2'b10) begin
                seen = 1;
                tests++;
                if (bus.ballX !== 10'd992 || !last_miss) begin
                    fails++;
                    $display("FAIL miss_entry got x=%0d pulse=%0b want x=992 pulse=1", bus.ballX, last_miss);
                end
            end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL miss_timeout got state=%0d want 2", bus.state); end
        n = 0;
        while (bus.state == 2'b10 && n < 100) begin
            bus.paddleY = 10'($urandom_range(0, 672));
            frame(1, 1);
            n++;
        end
        tests++;
        if (n != MISS_N || bus.ballX !== 10'd504 || bus.ballY !== 10'd376 || bus.ballVisible !== 1'b0) begin
            fails++;
            $display("FAIL miss_to_idle got ticks=%0d (%0d,%0d) vis=%0b want ticks=60 (504,376) vis=0",
                     n, bus.ballX, bus.ballY, bus.ballVisible);
        end
        tests++;
        if (mm_cnt != 0) begin fails++; $display("FAIL miss_model got=%h want=%h", mm_got, mm_exp); end
    endtask

    task automatic test_vsync_held();
        int changes;
        logic [9:0] px;
        mm_cnt = 0;
        restart(1'b0);
        frame(2, 1);
        px = bus.ballX;
        changes = 0;
        bus.vSync = 1'b1;
        repeat (20) begin
            step();
            if (bus.ballX !== px) changes++;
            px = bus.ballX;
        end
        bus.vSync = 1'b0; step();
        tests++;
        if (changes != 1) begin fails++; $display("FAIL vsync_held got %0d updates want 1", changes); end
        tests++;
        if (mm_cnt != 0) begin fails++; $display("FAIL vsync_model got=%h want=%h", mm_got, mm_exp); end
    endtask

    task automatic test_reset_mid_run();
        mm_cnt = 0;
        restart(1'b1);
        repeat (5) frame(1, 1);
        bus.vSync = 1'b1;   // a tick pending in the same cycle as reset
        rst = 1'b1; step();
        rst = 1'b0; bus.vSync = 1'b0;
        tests++;
        if (bus.state !== 2'b00 || bus.ballX !== 10'd504 || bus.ballY !== 10'd376 || bus.ballVisible !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run got state=%0d (%0d,%0d) want 0 (504,376)", bus.state, bus.ballX, bus.ballY);
        end
        step();
        tests++;
        if (mm_cnt != 0) begin fails++; $display("FAIL reset_mid_model got=%h want=%h", mm_got, mm_exp); end
    endtask

    task automatic test_random_play();
        int ymin, ymax, xmin, hits;
        mm_cnt = 0;
        ymin = 1023; ymax = 0; xmin = 1023; hits = 0;
        restart($urandom_range(0, 1) == 1);
        for (int f = 0; f < 2500; f++) begin
            bus.paddleY = ($urandom_range(0, 9) < 8) ? track_pad() : 10'($urandom_range(0, 1023));
            bus.serve   = ($urandom_range(0, 3) == 0);
            bus.serveUp = $urandom_range(0, 1) == 1;
            frame($urandom_range(0, 3), $urandom_range(1, 3));
            if (last_hit) hits++;
            if (bus.state == 2'b01) begin
                if (int'(bus.ballY) < ymin) ymin = int'(bus.ballY);
                if (int'(bus.ballY) > ymax) ymax = int'(bus.ballY);
                if (int'(bus.ballX) < xmin) xmin = int'(bus.ballX);
            end
        end
        bus.serve = 1'b0;
        tests++;
        if (ymin != 16 || ymax != 736 || xmin != 16) begin
            fails++;
            $display("FAIL random_walls got ymin=%0d ymax=%0d xmin=%0d want 16/736/16", ymin, ymax, xmin);
        end
        tests++;
        if (hits == 0) begin fails++; $display("FAIL random_hits got 0 hits want >0"); end
        tests++;
        if (mm_cnt != 0) begin
            fails++;
            $display("FAIL random_model got=%h want=%h (%0d bad cycles)", mm_got, mm_exp, mm_cnt);
        end
    endtask

    initial begin
        model_reset();
        bus.vSync = 1'b0; bus.serve = 1'b0; bus.serveUp = 1'b0; bus.paddleY = 10'd0;
        last_hit = 0; last_miss = 0;
        test_reset();
        test_serve();
        test_hit();
        test_miss();
        test_vsync_held();
        test_reset_mid_run();
        test_random_play();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
